// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns received MOSI bytes into motor duty/direction
// updates, encoder soft resets and count read-back on MISO.
module spi_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic [15:0] pitch_count,
  input  logic [15:0] yaw_count,
  output logic [7:0]  tx_byte,
  output logic        tx_load,
  output logic [15:0] pitch_duty,
  output logic [15:0] yaw_duty,
  output logic        pitch_dir,
  output logic        yaw_dir,
  output logic        soft_rst,
  output logic        cmd_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SET_DIR, SET_HI, SET_LO, GET_HI, GET_LO} state_t;

  state_t             state, state_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic               tgt_yaw, tgt_yaw_nxt;
  logic               dir_shadow, dir_shadow_nxt;
  logic [7:0]         duty_hi_shadow, duty_hi_shadow_nxt;
  logic signed [15:0] snapshot, snapshot_nxt;
  logic [7:0]         tx_byte_nxt;
  logic               tx_load_nxt, soft_rst_nxt, cmd_err_nxt;
  logic [15:0]        pitch_duty_nxt, yaw_duty_nxt;
  logic               pitch_dir_nxt, yaw_dir_nxt;
  logic               timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      to_cnt         <= '0;
      tgt_yaw        <= 1'b0;
      dir_shadow     <= 1'b0;
      duty_hi_shadow <= 8'h00;
      snapshot       <= 16'sh0000;
      tx_byte        <= 8'h00;
      tx_load        <= 1'b0;
      soft_rst       <= 1'b0;
      cmd_err        <= 1'b0;
      pitch_duty     <= 16'h0000;
      yaw_duty       <= 16'h0000;
      pitch_dir      <= 1'b0;
      yaw_dir        <= 1'b0;
    end else begin
      state          <= state_nxt;
      to_cnt         <= to_cnt_nxt;
      tgt_yaw        <= tgt_yaw_nxt;
      dir_shadow     <= dir_shadow_nxt;
      duty_hi_shadow <= duty_hi_shadow_nxt;
      snapshot       <= snapshot_nxt;
      tx_byte        <= tx_byte_nxt;
      tx_load        <= tx_load_nxt;
      soft_rst       <= soft_rst_nxt;
      cmd_err        <= cmd_err_nxt;
      pitch_duty     <= pitch_duty_nxt;
      yaw_duty       <= yaw_duty_nxt;
      pitch_dir      <= pitch_dir_nxt;
      yaw_dir        <= yaw_dir_nxt;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = (state != IDLE) && !rx_valid && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt          = state;
    tgt_yaw_nxt        = tgt_yaw;
    dir_shadow_nxt     = dir_shadow;
    duty_hi_shadow_nxt = duty_hi_shadow;
    snapshot_nxt       = snapshot;
    tx_byte_nxt        = tx_byte;
    tx_load_nxt        = 1'b0;
    soft_rst_nxt       = 1'b0;
    cmd_err_nxt        = 1'b0;
    pitch_duty_nxt     = pitch_duty;
    yaw_duty_nxt       = yaw_duty;
    pitch_dir_nxt      = pitch_dir;
    yaw_dir_nxt        = yaw_dir;
    to_cnt_nxt         = (rx_valid || state == IDLE) ? '0 : to_cnt + 1'b1;

    if (rx_valid) begin
      case (state)
        IDLE: begin
          case (rx_byte)
            8'hFF: begin
              soft_rst_nxt   = 1'b1;
              pitch_duty_nxt = 16'h0000;
              yaw_duty_nxt   = 16'h0000;
              pitch_dir_nxt  = 1'b0;
              yaw_dir_nxt    = 1'b0;
            end
            8'h11, 8'h21: begin
              tgt_yaw_nxt = rx_byte[5];
              state_nxt   = SET_DIR;
            end
            8'h12, 8'h22: begin
              snapshot_nxt = rx_byte[5] ? signed'(yaw_count) : signed'(pitch_count);
              tx_byte_nxt  = rx_byte[5] ? yaw_count[15:8] : pitch_count[15:8];
              tx_load_nxt  = 1'b1;
              state_nxt    = GET_HI;
            end
            default: cmd_err_nxt = 1'b1;
          endcase
        end
        SET_DIR: begin
          dir_shadow_nxt = rx_byte[0];
          state_nxt      = SET_HI;
        end
        SET_HI: begin
          duty_hi_shadow_nxt = rx_byte;
          state_nxt          = SET_LO;
        end
        SET_LO: begin
          // Direction and both duty bytes land on the same edge.
          if (tgt_yaw) begin
            yaw_duty_nxt = {duty_hi_shadow, rx_byte};
            yaw_dir_nxt  = dir_shadow;
          end else begin
            pitch_duty_nxt = {duty_hi_shadow, rx_byte};
            pitch_dir_nxt  = dir_shadow;
          end
          state_nxt = IDLE;
        end
        GET_HI: begin
          tx_byte_nxt = snapshot[7:0];
          tx_load_nxt = 1'b1;
          state_nxt   = GET_LO;
        end
        GET_LO: begin
          tx_byte_nxt = 8'h00;
          tx_load_nxt = 1'b1;
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt   = IDLE;
      cmd_err_nxt = 1'b1;
      tx_byte_nxt = 8'h00;
      to_cnt_nxt  = '0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: a vector table for single-strobe
// behaviour plus hand sequences for timeout and reset corner cases.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [15:0] pitch_count, yaw_count;
  logic [7:0]  tx_byte;
  logic        tx_load;
  logic [15:0] pitch_duty, yaw_duty;
  logic        pitch_dir, yaw_dir, soft_rst, cmd_err;

  int checks = 0;
  int errors = 0;

  spi_cmd_decoder #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .pitch_count(pitch_count), .yaw_count(yaw_count),
    .tx_byte(tx_byte), .tx_load(tx_load),
    .pitch_duty(pitch_duty), .yaw_duty(yaw_duty),
    .pitch_dir(pitch_dir), .yaw_dir(yaw_dir),
    .soft_rst(soft_rst), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  b;
    logic [15:0] pc, yc;
    logic [7:0]  tx;
    logic        ld;
    logic [15:0] pd;
    logic        pdir;
    logic [15:0] yd;
    logic        ydir, srst, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic vld, input logic [7:0] b,
                             input logic [15:0] pc, input logic [15:0] yc,
                             input logic [7:0] tx, input logic ld,
                             input logic [15:0] pd, input logic pdir,
                             input logic [15:0] yd, input logic ydir,
                             input logic srst, input logic err);
    vec_t r;
    r.vld = vld; r.b = b; r.pc = pc; r.yc = yc; r.tx = tx; r.ld = ld;
    r.pd = pd; r.pdir = pdir; r.yd = yd; r.ydir = ydir; r.srst = srst; r.err = err;
    return r;
  endfunction

  function automatic logic [44:0] outs();
    return {tx_byte, tx_load, pitch_duty, pitch_dir, yaw_duty, yaw_dir, soft_rst, cmd_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one strobe; returns sampled #1 after the edge that consumed it.
  task automatic strobe(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    pitch_count = 16'h0000; yaw_count = 16'h0000;
    idle(2);
    chk("reset_outputs", 64'(outs()), 64'(45'h0));
    rst_n = 1'b1;

    //        vld b      pc       yc       tx     ld pd       pdir yd       ydir srst err
    vecs.push_back(v(1, 8'h11, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h01, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h02, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h40, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h12, 16'h1234, 16'h0000, 8'h12, 1, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h00, 16'h9999, 16'h0000, 8'h34, 1, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h00, 16'h9999, 16'h0000, 8'h00, 1, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h55, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'h0000, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h21, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 16'h0000, 16'h0000, 8'h00, 0, 16'h0240, 1, 16'hFFFF, 1, 0, 0));
    vecs.push_back(v(1, 8'h22, 16'h0000, 16'hABCD, 8'hAB, 1, 16'h0240, 1, 16'hFFFF, 1, 0, 0));
    vecs.push_back(v(1, 8'h77, 16'h0000, 16'h1111, 8'hCD, 1, 16'h0240, 1, 16'hFFFF, 1, 0, 0));
    vecs.push_back(v(1, 8'hFF, 16'h0000, 16'h1111, 8'h00, 1, 16'h0240, 1, 16'hFFFF, 1, 0, 0));
    vecs.push_back(v(1, 8'h12, 16'hFEDC, 16'h0000, 8'hFE, 1, 16'h0240, 1, 16'hFFFF, 1, 0, 0));
    vecs.push_back(v(1, 8'h00, 16'h0101, 16'h0000, 8'hDC, 1, 16'h0240, 1, 16'hFFFF, 1, 0, 0));
    vecs.push_back(v(1, 8'h00, 16'h0101, 16'h0000, 8'h00, 1, 16'h0240, 1, 16'hFFFF, 1, 0, 0));
    vecs.push_back(v(1, 8'hFF, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h21, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h03, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h80, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 8'h01, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h8001, 1, 0, 0));
    vecs.push_back(v(1, 8'h00, 16'h0000, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h8001, 1, 0, 1));

    foreach (vecs[i]) begin
      rx_valid    = vecs[i].vld;
      rx_byte     = vecs[i].b;
      pitch_count = vecs[i].pc;
      yaw_count   = vecs[i].yc;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vecs[i].tx, vecs[i].ld, vecs[i].pd, vecs[i].pdir, vecs[i].yd,
               vecs[i].ydir, vecs[i].srst, vecs[i].err}));
    end

    // Timeout mid set sequence: no commit, then next byte is an opcode.
    strobe(8'h11);
    strobe(8'h01);
    n = 0;
    while (!cmd_err && n < 40) begin @(posedge clk); #1; n++; end
    chk("set_timeout_seen", 64'(cmd_err), 64'(1));
    chk("set_timeout_cycles", 64'(n >= 20 && n <= 21), 64'(1));
    chk("set_timeout_no_commit", 64'({pitch_duty, pitch_dir, tx_load}), 64'({16'h0000, 1'b0, 1'b0}));
    idle(1);
    chk("set_timeout_pulse_width", 64'(cmd_err), 64'(0));
    pitch_count = 16'h5AA5;
    strobe(8'h12);
    chk("get_after_timeout_hi", 64'({tx_byte, tx_load}), 64'({8'h5A, 1'b1}));
    strobe(8'h00);
    chk("get_after_timeout_lo", 64'({tx_byte, tx_load}), 64'({8'hA5, 1'b1}));

    // Timeout in GET_LO clears tx_byte without a load strobe.
    n = 0;
    while (!cmd_err && n < 40) begin @(posedge clk); #1; n++; end
    chk("get_timeout_tx", 64'({cmd_err, tx_byte, tx_load}), 64'({1'b1, 8'h00, 1'b0}));

    // A byte landing on the expiry cycle is processed, not timed out.
    idle(1);
    strobe(8'h11);
    seen = 1'b0;
    repeat (19) begin @(posedge clk); #1; seen |= cmd_err; end
    strobe(8'h01);
    seen |= cmd_err;
    strobe(8'h02);
    seen |= cmd_err;
    strobe(8'h03);
    seen |= cmd_err;
    chk("rx_wins_over_timeout", 64'({seen, pitch_duty, pitch_dir}), 64'({1'b0, 16'h0203, 1'b1}));

    // Reset mid-command abandons it; the next byte decodes as an opcode.
    strobe(8'h21);
    strobe(8'h00);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("reset_mid_cmd", 64'(outs()), 64'(45'h0));
    yaw_count = 16'h3C5A;
    strobe(8'h22);
    chk("get_after_reset_hi", 64'({tx_byte, tx_load, yaw_duty, yaw_dir}), 64'({8'h3C, 1'b1, 16'h0000, 1'b0}));
    strobe(8'h00);
    chk("get_after_reset_lo", 64'({tx_byte, tx_load}), 64'({8'h5A, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
